// File: rtl/pcpi_mm_pkg.sv
// Shared definitions for the fused matrix-multiply coprocessor and its PCPI host:
// custom-0 instruction fields, the operand address map and the host command format.
package pcpi_mm_pkg;

   localparam logic [6:0] CUSTOM0_OPCODE = 7'b0001011;

   localparam logic [2:0] FUNCT3_LOAD  = 3'b000;
   localparam logic [2:0] FUNCT3_STOP  = 3'b101;
   localparam logic [2:0] FUNCT3_START = 3'b111;

   localparam logic [4:0] A_BASE      = 5'd0;
   localparam logic [4:0] B_BASE      = 5'd9;
   localparam logic [4:0] BIAS_BASE   = 5'd18;
   localparam logic [4:0] THRESH_ADDR = 5'd27;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'd0,
      OP_STOP  = 2'd1,
      OP_START = 2'd2,
      OP_RSVD  = 2'd3
   } cmd_op_e;

   typedef struct packed {
      cmd_op_e     op;
      logic [4:0]  addr;
      logic [15:0] data;
   } host_cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_GAP
   } host_state_e;

   // STOP and START carry no operand, so their addr/data fields are forced to zero.
   function automatic logic [31:0] encode_insn(host_cmd_t cmd);
      logic [2:0]  funct3;
      logic [4:0]  addr;
      logic [15:0] data;
      funct3 = FUNCT3_LOAD;
      addr   = cmd.addr;
      data   = cmd.data;
      case (cmd.op)
         OP_STOP:  begin funct3 = FUNCT3_STOP;  addr = '0; data = '0; end
         OP_START: begin funct3 = FUNCT3_START; addr = '0; data = '0; end
         default:  ;
      endcase
      return {1'b0, data, funct3, addr, CUSTOM0_OPCODE};
   endfunction

endpackage

// File: rtl/pcpi_cmd_fifo.sv
// Synchronous command FIFO holding {op, addr, data} host commands.
// Pointers carry one extra wrap bit so full and empty are told apart without a counter.
module pcpi_cmd_fifo
   import pcpi_mm_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      push,
   input  logic      pop,
   input  host_cmd_t din,
   output host_cmd_t dout,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);

   host_cmd_t      mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;

   // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // NOTE: the storage array is deliberately not reset; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/pcpi_matrix_host.sv
// Standalone PCPI initiator: queues host commands, issues each as a custom-0 instruction,
// holds pcpi_valid until the coprocessor completes (or times out) and returns one response.
module pcpi_matrix_host
   import pcpi_mm_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64,
   parameter int MIN_HOLD   = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_addr,
   input  logic [15:0] cmd_data,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        pcpi_valid,
   output logic [31:0] pcpi_insn,
   input  logic        pcpi_wr,
   input  logic [31:0] pcpi_rd,
   input  logic        pcpi_wait,
   input  logic        pcpi_ready
);

   localparam int                CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0]  HOLD_MIN = CNT_W'(MIN_HOLD);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   host_state_e      state, state_d;
   host_cmd_t        fifo_din, fifo_dout;
   logic             fifo_full, fifo_empty, push, pop;
   logic             is_start, is_start_d;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_d;
   logic             pcpi_valid_d, rsp_valid_d, rsp_err_d, completion;
   logic [31:0]      pcpi_insn_d, rsp_data_d;
   logic             unused_wait;

   assign unused_wait = pcpi_wait;

   // A full FIFO still accepts a command in the cycle the FSM pops the head.
   assign pop       = (state == S_IDLE) && !fifo_empty;
   assign cmd_ready = !fifo_full || pop;
   assign push      = cmd_valid && cmd_ready;
   assign fifo_din  = '{op: cmd_op_e'(cmd_op), addr: cmd_addr, data: cmd_data};
   assign busy      = (state != S_IDLE) || !fifo_empty;

   pcpi_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // One counter serves as both hold and timeout count: both clear at issue and tick in WAIT.
   assign completion = pcpi_ready && (!is_start || wait_cnt >= HOLD_MIN);

   always_comb begin
      // NOTE: every value is defaulted first so no path through the case infers a latch.
      state_d      = state;
      pcpi_valid_d = pcpi_valid;
      pcpi_insn_d  = pcpi_insn;
      rsp_valid_d  = 1'b0;
      rsp_err_d    = 1'b0;
      rsp_data_d   = rsp_data;
      is_start_d   = is_start;
      wait_cnt_d   = wait_cnt;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               if (fifo_dout.op == OP_RSVD) begin
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = 1'b1;
                  rsp_data_d  = '0;
               end else begin
                  pcpi_insn_d = encode_insn(fifo_dout);
                  is_start_d  = (fifo_dout.op == OP_START);
                  state_d     = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            pcpi_valid_d = 1'b1;
            wait_cnt_d   = '0;
            state_d      = S_WAIT;
         end
         S_WAIT: begin
            if (completion) begin
               rsp_valid_d  = 1'b1;
               rsp_data_d   = pcpi_wr ? pcpi_rd : 32'h0;
               pcpi_valid_d = 1'b0;
               state_d      = S_GAP;
            end else if (wait_cnt == CNT_LAST) begin
               // pcpi_valid has now been held for TIMEOUT cycles with no completion.
               rsp_valid_d  = 1'b1;
               rsp_err_d    = 1'b1;
               rsp_data_d   = '0;
               pcpi_valid_d = 1'b0;
               state_d      = S_GAP;
            end else begin
               wait_cnt_d = wait_cnt + 1'b1;
            end
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         pcpi_valid <= 1'b0;
         pcpi_insn  <= '0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_data   <= '0;
         is_start   <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         state      <= state_d;
         pcpi_valid <= pcpi_valid_d;
         pcpi_insn  <= pcpi_insn_d;
         rsp_valid  <= rsp_valid_d;
         rsp_err    <= rsp_err_d;
         rsp_data   <= rsp_data_d;
         is_start   <= is_start_d;
         wait_cnt   <= wait_cnt_d;
      end
   end

endmodule

// File: tb/tb_pcpi_matrix_host.sv
// Scoreboard bench for pcpi_matrix_host: stimulus pushes expected responses, a monitor
// pops and compares them, and a scripted responder plays the coprocessor side.
module tb_pcpi_matrix_host;

   localparam int FIFO_DEPTH = 4;
   localparam int TIMEOUT    = 64;
   localparam int MIN_HOLD   = 2;
   localparam int NEVER      = 100000;

   logic        clk, rst;
   logic        cmd_valid, cmd_ready;
   logic [1:0]  cmd_op;
   logic [4:0]  cmd_addr;
   logic [15:0] cmd_data;
   logic        rsp_valid, rsp_err, busy, pcpi_valid;
   logic [31:0] rsp_data, pcpi_insn, pcpi_rd;
   logic        pcpi_wr, pcpi_wait, pcpi_ready;

   // Responder behaviour for one instruction: ready on the first valid cycle if early,
   // and from cycle lat onward; wr/rd are what it returns on completion.
   typedef struct {
      bit          early;
      int          lat;
      bit          wr;
      logic [31:0] rd;
   } plan_t;

   typedef struct {
      bit          err;
      logic [31:0] data;
      bit          via_pcpi;
   } rsp_t;

   plan_t       plan_q[$];
   rsp_t        rsp_q[$];
   logic [31:0] insn_q[$];
   int          dur_q[$];

   int passed = 0;
   int total  = 0;

   pcpi_matrix_host #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .TIMEOUT    (TIMEOUT),
      .MIN_HOLD   (MIN_HOLD)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_addr   (cmd_addr),
      .cmd_data   (cmd_data),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .rsp_data   (rsp_data),
      .busy       (busy),
      .pcpi_valid (pcpi_valid),
      .pcpi_insn  (pcpi_insn),
      .pcpi_wr    (pcpi_wr),
      .pcpi_rd    (pcpi_rd),
      .pcpi_wait  (pcpi_wait),
      .pcpi_ready (pcpi_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected normal completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp)
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      else
         passed++;
   endtask

   // Instruction word straight from the field layout of the custom-0 format.
   function automatic logic [31:0] exp_insn(input logic [1:0] op, input logic [4:0] a,
                                            input logic [15:0] d);
      case (op)
         2'd0:    return {1'b0, d,     3'b000, a,    7'b0001011};
         2'd1:    return {1'b0, 16'h0, 3'b101, 5'h0, 7'b0001011};
         default: return {1'b0, 16'h0, 3'b111, 5'h0, 7'b0001011};
      endcase
   endfunction

   // Outcome of one issued instruction: first cycle (counted from the first valid cycle)
   // where the responder is ready and, for START, the hold window has passed.
   function automatic void model(input logic [1:0] op, input plan_t p,
                                 output bit err, output int dur);
      bit rdy;
      err = 1'b1;
      dur = TIMEOUT;
      for (int k = 0; k < TIMEOUT; k++) begin
         rdy = (p.early && k == 0) || (k >= p.lat);
         if (rdy && (op != 2'd2 || k >= MIN_HOLD)) begin
            err = 1'b0;
            dur = k + 1;
            return;
         end
      end
   endfunction

   function automatic plan_t mk_plan(input bit early, input int lat, input bit wr,
                                     input logic [31:0] rd);
      plan_t p;
      p.early = early;
      p.lat   = lat;
      p.wr    = wr;
      p.rd    = rd;
      return p;
   endfunction

   task automatic push_cmd(input logic [1:0] op, input logic [4:0] a, input logic [15:0] d,
                           input plan_t p);
      int   waited;
      bit   err;
      int   dur;
      rsp_t r;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      waited    = 0;
      while (!cmd_ready && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      if (!cmd_ready) begin
         total++;
         $display("FAIL push_stall: cmd_ready low for %0d cycles, expected it to rise", waited);
         cmd_valid = 1'b0;
         return;
      end
      if (op == 2'd3) begin
         r.err = 1'b1; r.data = '0; r.via_pcpi = 1'b0;
      end else begin
         model(op, p, err, dur);
         insn_q.push_back(exp_insn(op, a, d));
         dur_q.push_back(dur);
         plan_q.push_back(p);
         r.err      = err;
         r.data     = (!err && p.wr) ? p.rd : 32'h0;
         r.via_pcpi = 1'b1;
      end
      rsp_q.push_back(r);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((rsp_q.size() != 0 || busy) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_pending", rsp_q.size(), 0);
      check("drain_busy", busy, 1'b0);
   endtask

   task automatic wait_valid();
      int n = 0;
      while (!pcpi_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!pcpi_valid) begin
         total++;
         $display("FAIL valid_wait: pcpi_valid still 0 after %0d cycles, expected 1", n);
      end
   endtask

   // Coprocessor side: reacts on the falling edge to what the DUT drove at the rising edge.
   initial begin : responder
      plan_t cur;
      int    k;
      bit    prev_v;
      prev_v = 1'b0;
      k      = 0;
      cur    = mk_plan(1'b0, NEVER, 1'b0, 32'h0);
      forever begin
         @(negedge clk);
         if (pcpi_valid) begin
            if (!prev_v) begin
               k = 0;
               if (plan_q.size() > 0) cur = plan_q.pop_front();
               else                   cur = mk_plan(1'b0, NEVER, 1'b0, 32'h0);
            end else begin
               k++;
            end
            pcpi_ready = (cur.early && k == 0) || (k >= cur.lat);
            pcpi_wr    = pcpi_ready && cur.wr;
            pcpi_rd    = pcpi_ready ? cur.rd : $urandom;
            pcpi_wait  = !pcpi_ready;
         end else begin
            pcpi_ready = 1'b0;
            pcpi_wr    = 1'b0;
            pcpi_rd    = 32'h0;
            pcpi_wait  = 1'b0;
         end
         prev_v = pcpi_valid;
      end
   end

   initial begin : monitor
      bit          in_flight, insn_moved, fell;
      int          vcnt, cur_dur;
      logic [31:0] cur_insn;
      rsp_t        r;
      in_flight = 1'b0;
      forever begin
         @(negedge clk);
         fell = 1'b0;
         if (rst) begin
            in_flight = 1'b0;
         end else begin
            if (pcpi_valid) begin
               if (!in_flight) begin
                  in_flight  = 1'b1;
                  vcnt       = 1;
                  insn_moved = 1'b0;
                  cur_insn   = pcpi_insn;
                  if (insn_q.size() == 0) begin
                     total++;
                     cur_dur = -1;
                     $display("FAIL unexpected_issue: insn 0x%08h, expected no instruction",
                              pcpi_insn);
                  end else begin
                     check("pcpi_insn", pcpi_insn, insn_q.pop_front());
                     cur_dur = dur_q.pop_front();
                  end
               end else begin
                  vcnt++;
                  if (pcpi_insn !== cur_insn) insn_moved = 1'b1;
               end
            end else if (in_flight) begin
               in_flight = 1'b0;
               fell      = 1'b1;
               check("valid_cycles", vcnt, cur_dur);
               check("insn_stable", insn_moved, 1'b0);
            end
            if (rsp_valid) begin
               if (rsp_q.size() == 0) begin
                  total++;
                  $display("FAIL unexpected_rsp: err=%0b data=0x%08h, expected no response",
                           rsp_err, rsp_data);
               end else begin
                  r = rsp_q.pop_front();
                  check("rsp_err", rsp_err, r.err);
                  check("rsp_data", rsp_data, r.data);
                  check("rsp_with_release", fell, r.via_pcpi);
               end
            end
         end
      end
   end

   initial begin : stimulus
      int          n;
      int          sel;
      logic [1:0]  op;
      logic [15:0] d;
      plan_t       p;

      rst        = 1'b1;
      cmd_valid  = 1'b0;
      cmd_op     = 2'd0;
      cmd_addr   = 5'd0;
      cmd_data   = 16'd0;
      pcpi_ready = 1'b0;
      pcpi_wr    = 1'b0;
      pcpi_rd    = 32'h0;
      pcpi_wait  = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_pcpi_valid", pcpi_valid, 1'b0);
      check("rst_pcpi_insn", pcpi_insn, 32'h0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_err", rsp_err, 1'b0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_cmd_ready", cmd_ready, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // LOAD against an idle responder: response three cycles after acceptance.
      push_cmd(2'd0, 5'd4, 16'h1234, mk_plan(1'b0, 0, 1'b0, 32'hDEAD_BEEF));
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("load_rsp_latency", n, 3);
      wait_idle();

      // Reserved op: error response straight from the pop, no PCPI traffic.
      push_cmd(2'd3, 5'd7, 16'h5555, mk_plan(1'b0, 0, 1'b0, 32'h0));
      n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("rsvd_rsp_latency", n, 1);
      wait_idle();

      // Slow START occupies the responder while four LOADs fill the FIFO; the fifth stalls.
      push_cmd(2'd2, 5'd0, 16'h0, mk_plan(1'b0, 30, 1'b1, 32'h0000_00A5));
      wait_valid();
      for (int i = 0; i < FIFO_DEPTH; i++)
         push_cmd(2'd0, 5'(9 + i), 16'(16'h0100 + i), mk_plan(1'b0, 0, 1'b1, 32'(i + 100)));
      check("full_cmd_ready", cmd_ready, 1'b0);
      check("full_busy", busy, 1'b1);
      push_cmd(2'd0, 5'd27, 16'h7FFF, mk_plan(1'b0, 1, 1'b1, 32'h1234_5678));
      wait_idle();

      // START with a stale early ready: ignored, then completes on cycle ten.
      push_cmd(2'd2, 5'd0, 16'h0, mk_plan(1'b1, 9, 1'b1, 32'hCAFE_0001));
      wait_idle();

      // START the responder never finishes, with a LOAD queued behind it.
      push_cmd(2'd2, 5'd0, 16'h0, mk_plan(1'b0, NEVER, 1'b1, 32'hFFFF_FFFF));
      push_cmd(2'd0, 5'd18, 16'h8001, mk_plan(1'b0, 2, 1'b1, 32'h0BAD_F00D));
      wait_idle();

      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         op  = (sel < 5) ? 2'd0 : (sel < 7) ? 2'd2 : (sel < 9) ? 2'd1 : 2'd3;
         d   = 16'($urandom);
         p   = mk_plan(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 19) == 0) ? NEVER : $urandom_range(0, 12),
                       1'($urandom_range(0, 1)), $urandom);
         push_cmd(op, 5'($urandom_range(0, 27)), d, p);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();

      // Reset in the middle of a START that would otherwise time out.
      push_cmd(2'd2, 5'd0, 16'h0, mk_plan(1'b0, NEVER, 1'b0, 32'h0));
      wait_valid();
      repeat (5) @(negedge clk);
      rst = 1'b1;
      plan_q.delete();
      rsp_q.delete();
      insn_q.delete();
      dur_q.delete();
      @(negedge clk);
      check("midrst_pcpi_valid", pcpi_valid, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_cmd_ready", cmd_ready, 1'b1);
      check("midrst_rsp_valid", rsp_valid, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      repeat (TIMEOUT + 10) @(negedge clk);

      push_cmd(2'd0, 5'd27, 16'hFFFF, mk_plan(1'b0, 3, 1'b1, 32'h600D_0001));
      wait_idle();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
